// File: rtl/spi_shift_engine_if.sv
// Parallel-word handshake, divider strobes and serial pins for spi_shift_engine.
// The engine takes the slave view; whatever feeds it words and strobes takes the master view.
interface spi_shift_engine_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              div_valid;
    logic              leading_edge;
    logic              trailing_edg;
    logic              miso;
    logic              mosi;
    logic              ss_n;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              err;

    modport master (
        output tx_data, tx_valid, leading_edge, trailing_edg, miso,
        input  tx_ready, div_valid, mosi, ss_n, rx_data, rx_valid, busy, err
    );

    modport slave (
        input  tx_data, tx_valid, leading_edge, trailing_edg, miso,
        output tx_ready, div_valid, mosi, ss_n, rx_data, rx_valid, busy, err
    );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI master shift engine, CPOL=1/CPHA=1: drives MOSI on SCLK falling, samples MISO on rising.
// Define SPI_LSB_FIRST_EN to shift LSB first; MSB first otherwise.
module spi_shift_engine #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    spi_shift_engine_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam int WD_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WD_W-1:0]   r_wd_cnt;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_rx_sh;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_tx_ready;
    logic              r_div_valid;
    logic              r_mosi;
    logic              r_ss_n;
    logic              r_rx_valid;
    logic              r_busy;
    logic              r_err;

    logic              w_accept;
    logic              w_lead;
    logic              w_trail;
    logic              w_timeout;
    logic              w_tx_bit;
    logic [DATA_W-1:0] w_tx_next;
    logic [DATA_W-1:0] w_rx_next;

    assign w_accept  = (r_state == IDLE) && bus.tx_valid && r_tx_ready;
    assign w_lead    = (r_state == SHIFT) && bus.leading_edge;
    assign w_trail   = (r_state == SHIFT) && bus.trailing_edg;
    // Fires on the cycle the idle count would reach TIMEOUT_CYC.
    assign w_timeout = (TIMEOUT_CYC > 0) && (r_state == SHIFT) &&
                       !bus.leading_edge && !bus.trailing_edg && (r_wd_cnt == WD_LAST);

`ifdef SPI_LSB_FIRST_EN
    assign w_tx_bit  = r_tx_sh[0];
    assign w_tx_next = {1'b0, r_tx_sh[DATA_W-1:1]};
    assign w_rx_next = {bus.miso, r_rx_sh[DATA_W-1:1]};
`else
    assign w_tx_bit  = r_tx_sh[DATA_W-1];
    assign w_tx_next = {r_tx_sh[DATA_W-2:0], 1'b0};
    assign w_rx_next = {r_rx_sh[DATA_W-2:0], bus.miso};
`endif

    // Shift registers carry no reset: they are always reloaded on accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tx_sh <= bus.tx_data;
            r_rx_sh <= '0;
        end else begin
            if (w_lead)  r_tx_sh <= w_tx_next;
            if (w_trail) r_rx_sh <= w_rx_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_wd_cnt    <= '0;
            r_tx_ready  <= 1'b1;
            r_div_valid <= 1'b0;
            r_mosi      <= 1'b1;
            r_ss_n      <= 1'b1;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_div_valid <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state     <= SHIFT;
                        r_bit_cnt   <= '0;
                        r_wd_cnt    <= '0;
                        r_tx_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_ss_n      <= 1'b0;
                        r_div_valid <= 1'b1;
                    end else begin
                        // Idle levels land one edge after DONE or an abort.
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_ss_n     <= 1'b1;
                        r_mosi     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_lead) r_mosi <= w_tx_bit;
                    if (bus.leading_edge || bus.trailing_edg) begin
                        r_wd_cnt <= '0;
                    end else if (TIMEOUT_CYC > 0) begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                    if (w_trail) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_BIT) r_state <= DONE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                DONE: begin
                    r_rx_data  <= r_rx_sh;
                    r_rx_valid <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.tx_ready  = r_tx_ready;
    assign bus.div_valid = r_div_valid;
    assign bus.mosi      = r_mosi;
    assign bus.ss_n      = r_ss_n;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: vector table, hand-built corner sequences and random transfers.
// Bit order follows SPI_LSB_FIRST_EN the same way the design does.
module tb_spi_shift_engine;
    localparam int W   = 8;
    localparam int TMO = 16;

    typedef struct {
        logic [W-1:0] tx;
        int           mode;     // 0: miso looped from mosi, 1: miso follows pat
        logic [W-1:0] pat;
        int           gap;
        bit           overlap;  // trailing of bit k shares a cycle with leading of bit k+1
        logic [W-1:0] exp_rx;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    vec_t         vecs[7];
    logic [W-1:0] mw, rw, prev_rx, rtx, rpat;
    int           waited, cnt, rmode, rgap;
    bit           saw_rx, rovl;

    spi_shift_engine_if #(.DATA_W(W)) bus ();

    spi_shift_engine #(.DATA_W(W), .TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=hung required=finished");
        $fatal(1, "simulation did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic gap(input int max_gap);
        repeat ($urandom_range(max_gap, 0)) tick();
    endtask

    // Wire slot k of a word: which data bit travels k-th on the serial line.
    function automatic logic wire_bit(input logic [W-1:0] word, input int k);
`ifdef SPI_LSB_FIRST_EN
        return word[k];
`else
        return word[W-1-k];
`endif
    endfunction

    // Rebuild a word from the bits seen on the wire, slot 0 first.
    function automatic logic [W-1:0] from_wire(input logic [W-1:0] slots);
        int unsigned v = 0;
        for (int k = 0; k < W; k++) begin
`ifdef SPI_LSB_FIRST_EN
            v = v + (int'(slots[k]) << k);
`else
            v = v * 2 + int'(slots[k]);
`endif
        end
        return W'(v);
    endfunction

    // One transfer acting as the divider and slave. Stops after nbits trailing edges.
    task automatic xfer(input logic [W-1:0] tx, input int mode, input logic [W-1:0] pat,
                        input int max_gap, input bit overlap, input int nbits,
                        input bit hold_next, input logic [W-1:0] next_tx,
                        output logic [W-1:0] mosi_word, output logic [W-1:0] miso_word,
                        output int wait_cyc);
        logic [W-1:0] mosi_slots;
        logic [W-1:0] miso_slots;
        logic         b;
        mosi_slots = '0;
        miso_slots = '0;
        wait_cyc   = 0;
        bus.tx_data  = tx;
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && wait_cyc < 50) begin
            tick();
            wait_cyc++;
        end
        chk("accept_ready", bus.tx_ready, 1);
        tick();
        if (hold_next) bus.tx_data = next_tx;
        else           bus.tx_valid = 1'b0;
        chk("start_div_valid", bus.div_valid, 1);
        chk("start_ready_busy_ssn", {bus.tx_ready, bus.busy, bus.ss_n}, 3'b010);
        tick();
        chk("div_valid_pulse", bus.div_valid, 0);
        for (int k = 0; k < nbits; k++) begin
            if (k == 0 || !overlap) begin
                gap(max_gap);
                bus.leading_edge = 1'b1;
                tick();
                bus.leading_edge = 1'b0;
                mosi_slots[k] = bus.mosi;
            end
            gap(max_gap);
            b = (mode == 0) ? bus.mosi : wire_bit(pat, k);
            miso_slots[k] = b;
            bus.miso = b;
            bus.trailing_edg = 1'b1;
            if (overlap && k < nbits - 1) bus.leading_edge = 1'b1;
            tick();
            if (bus.leading_edge) mosi_slots[k+1] = bus.mosi;
            bus.trailing_edg = 1'b0;
            bus.leading_edge = 1'b0;
            chk("ss_n_low", bus.ss_n, 0);
        end
        mosi_word = from_wire(mosi_slots);
        miso_word = from_wire(miso_slots);
        if (nbits == W) begin
            chk("pre_done_rx_valid", bus.rx_valid, 0);
            tick();
            chk("rx_valid", bus.rx_valid, 1);
            chk("rx_ss_n_still_low", bus.ss_n, 0);
            tick();
            chk("rx_valid_one_cycle", bus.rx_valid, 0);
            chk("idle_ready_busy_ssn_mosi", {bus.tx_ready, bus.busy, bus.ss_n, bus.mosi}, 4'b1011);
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 0, 8'h00, 1, 1'b0, 8'hA5};
        vecs[1] = '{8'hFF, 1, 8'h00, 2, 1'b0, 8'h00};
        vecs[2] = '{8'h00, 1, 8'hFF, 0, 1'b0, 8'hFF};
        vecs[3] = '{8'h81, 1, 8'h3C, 3, 1'b0, 8'h3C};
        vecs[4] = '{8'h96, 0, 8'h00, 0, 1'b1, 8'h96};
        vecs[5] = '{8'h01, 0, 8'h00, 1, 1'b0, 8'h01};
        vecs[6] = '{8'h5E, 1, 8'hC9, 0, 1'b1, 8'hC9};

        rst              = 1'b0;
        bus.tx_data      = '0;
        bus.tx_valid     = 1'b0;
        bus.leading_edge = 1'b0;
        bus.trailing_edg = 1'b0;
        bus.miso         = 1'b1;
        repeat (2) tick();
        chk("reset_outputs", {bus.tx_ready, bus.div_valid, bus.mosi, bus.ss_n,
                              bus.rx_valid, bus.busy, bus.err}, 7'b1011000);
        chk("reset_rx_data", bus.rx_data, 0);
        rst = 1'b1;
        tick();

        // Strobes while idle must not move anything.
        bus.leading_edge = 1'b1;
        bus.trailing_edg = 1'b1;
        bus.miso         = 1'b0;
        tick();
        bus.leading_edge = 1'b0;
        bus.trailing_edg = 1'b0;
        chk("idle_strobe_ignored", {bus.busy, bus.mosi, bus.rx_valid, bus.tx_ready}, 4'b0101);

        for (int i = 0; i < 7; i++) begin
            xfer(vecs[i].tx, vecs[i].mode, vecs[i].pat, vecs[i].gap, vecs[i].overlap, W,
                 1'b0, '0, mw, rw, waited);
            chk("vec_mosi_word", mw, vecs[i].tx);
            chk("vec_rx_data", bus.rx_data, vecs[i].exp_rx);
        end

        // Back-to-back with tx_valid held: second word taken one cycle after rx_valid.
        xfer(8'h3C, 0, '0, 3, 1'b0, W, 1'b1, 8'hC3, mw, rw, waited);
        chk("b2b_first_mosi", mw, 8'h3C);
        chk("b2b_first_rx", bus.rx_data, 8'h3C);
        xfer(8'hC3, 0, '0, 2, 1'b0, W, 1'b0, '0, mw, rw, waited);
        chk("b2b_accept_wait", waited, 0);
        chk("b2b_second_rx", bus.rx_data, 8'hC3);

        // Watchdog abort after three bits.
        prev_rx = bus.rx_data;
        xfer(8'h6B, 1, 8'hFF, 2, 1'b0, 3, 1'b0, '0, mw, rw, waited);
        cnt    = 0;
        saw_rx = 1'b0;
        while (!bus.err && cnt < 40) begin
            if (bus.rx_valid) saw_rx = 1'b1;
            tick();
            cnt++;
        end
        chk("tmo_cycles", cnt, TMO);
        chk("tmo_no_rx_valid", saw_rx | bus.rx_valid, 0);
        chk("tmo_rx_data_kept", bus.rx_data, prev_rx);
        tick();
        chk("tmo_err_pulse", bus.err, 0);
        chk("tmo_idle", {bus.tx_ready, bus.busy, bus.ss_n, bus.mosi}, 4'b1011);

        // Reset in the middle of a word, then a clean transfer.
        xfer(8'hE7, 0, '0, 2, 1'b0, 4, 1'b0, '0, mw, rw, waited);
        #2 rst = 1'b0;
        #1;
        chk("midrst_outputs", {bus.tx_ready, bus.div_valid, bus.mosi, bus.ss_n,
                               bus.rx_valid, bus.busy, bus.err}, 7'b1011000);
        chk("midrst_rx_data", bus.rx_data, 0);
        saw_rx = 1'b0;
        repeat (3) begin
            tick();
            if (bus.rx_valid || bus.err) saw_rx = 1'b1;
        end
        rst = 1'b1;
        repeat (2) begin
            tick();
            if (bus.rx_valid || bus.err) saw_rx = 1'b1;
        end
        chk("midrst_no_strobes", saw_rx, 0);
        xfer(8'h5A, 0, '0, 2, 1'b0, W, 1'b0, '0, mw, rw, waited);
        chk("post_rst_mosi", mw, 8'h5A);
        chk("post_rst_rx", bus.rx_data, 8'h5A);

        // Random transfers against the wire-slot model.
        for (int i = 0; i < 30; i++) begin
            rtx   = W'($urandom);
            rpat  = W'($urandom);
            rmode = int'($urandom_range(1, 0));
            rgap  = int'($urandom_range(4, 0));
            rovl  = 1'($urandom_range(1, 0));
            xfer(rtx, rmode, rpat, rgap, rovl, W, 1'b0, '0, mw, rw, waited);
            chk("rand_mosi_word", mw, rtx);
            chk("rand_rx_data", bus.rx_data, rw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
